// File: rtl/core_commit_tracer.sv
// Multi-channel commit tracer: packs up to NCH retiring instructions per cycle
// into a trace FIFO, counting commits and overflow drops. Optional timestamps: CORE_COMMIT_TS_EN.
module core_commit_tracer #(
    parameter int NCH   = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      commit_val,
    input  logic [NCH*XLEN-1:0] commit_pc,
    input  logic [NCH*XLEN-1:0] commit_data,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [CH_W-1:0]     out_ch,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_data,
    output logic [31:0]         out_ts,
    output logic [LVL_W-1:0]    level,
    output logic [CNT_W-1:0]    commit_cnt,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                ovf
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             head;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [LVL_W-1:0] level_q;

    logic             pop;
    logic [LVL_W-1:0] free;
    logic [LVL_W-1:0] n_valid;
    logic [LVL_W-1:0] n_wr;
    logic [LVL_W-1:0] n_drop;
    logic [LVL_W-1:0] rank [NCH];
    logic [NCH-1:0]   wr_en;
    logic [CNT_W:0]   drop_sum;

    assign out_val = (level_q != '0);
    assign level   = level_q;
    assign pop     = out_val & out_rdy;
    // A slot vacated by this cycle's pop can be refilled by this cycle's commits.
    assign free    = LVL_W'(DEPTH) - level_q + LVL_W'(pop);

    // Rank = number of valid lower-index channels; it is both the slot offset and the admission test.
    always_comb begin
        n_valid = '0;
        wr_en   = '0;
        for (int i = 0; i < NCH; i++) begin
            rank[i]  = n_valid;
            wr_en[i] = commit_val[i] && (n_valid < free);
            n_valid  = n_valid + LVL_W'(commit_val[i]);
        end
    end

    assign n_wr     = (n_valid < free) ? n_valid : free;
    assign n_drop   = n_valid - n_wr;
    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(n_drop);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst && wr_en[i]) begin
                mem[wptr + PTR_W'(rank[i])] <= '{ch:   CH_W'(i),
                                                 pc:   commit_pc[i*XLEN +: XLEN],
                                                 data: commit_data[i*XLEN +: XLEN]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr       <= '0;
            wptr       <= '0;
            level_q    <= '0;
            commit_cnt <= '0;
            drop_cnt   <= '0;
            ovf        <= 1'b0;
        end else begin
            rptr       <= rptr + PTR_W'(pop);
            wptr       <= wptr + PTR_W'(n_wr);
            level_q    <= level_q + n_wr - LVL_W'(pop);
            commit_cnt <= commit_cnt + CNT_W'(n_valid);
            drop_cnt   <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            ovf        <= ovf | (n_drop != '0);
        end
    end

    // Head fields read as zero when empty, so reset leaves every output at 0.
    assign head     = mem[rptr];
    assign out_ch   = out_val ? head.ch   : '0;
    assign out_pc   = out_val ? head.pc   : '0;
    assign out_data = out_val ? head.data : '0;

`ifdef CORE_COMMIT_TS_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst && wr_en[i]) ts_mem[wptr + PTR_W'(rank[i])] <= ts_cnt;
        end
    end

    assign out_ts = out_val ? ts_mem[rptr] : '0;
`else
    assign out_ts = '0;
`endif

endmodule

// File: tb/tb_core_commit_tracer.sv
// Self-checking bench for core_commit_tracer: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_core_commit_tracer;
    localparam int NCH   = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      commit_val;
    logic [NCH*XLEN-1:0] commit_pc;
    logic [NCH*XLEN-1:0] commit_data;
    logic                out_val;
    logic                out_rdy;
    logic [0:0]          out_ch;
    logic [XLEN-1:0]     out_pc;
    logic [XLEN-1:0]     out_data;
    logic [31:0]         out_ts;
    logic [3:0]          level;
    logic [CNT_W-1:0]    commit_cnt;
    logic [CNT_W-1:0]    drop_cnt;
    logic                ovf;

    always #5 clk = ~clk;

    core_commit_tracer #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .commit_val(commit_val), .commit_pc(commit_pc),
        .commit_data(commit_data), .out_val(out_val), .out_rdy(out_rdy), .out_ch(out_ch),
        .out_pc(out_pc), .out_data(out_data), .out_ts(out_ts), .level(level),
        .commit_cnt(commit_cnt), .drop_cnt(drop_cnt), .ovf(ovf)
    );

    typedef struct {
        int          ch;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] ts;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_cnt, m_drop, m_ts;
    bit          m_ovf;
    logic [31:0] pcv [NCH];
    logic [31:0] dv  [NCH];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(bit r, logic [NCH-1:0] v, bit rdy);
        rst        = r;
        commit_val = v;
        out_rdy    = rdy;
        for (int i = 0; i < NCH; i++) begin
            commit_pc[i*XLEN +: XLEN]   = pcv[i];
            commit_data[i*XLEN +: XLEN] = dv[i];
        end
    endtask

    // Reference: a record queue with DEPTH capacity, updated once per clock.
    task automatic model_update();
        int     sz, fr, wr, nv, dr;
        bit     pop;
        rec_t   r;
        longint s;
        if (rst) begin
            q.delete();
            m_cnt = 0; m_drop = 0; m_ovf = 0; m_ts = 0;
            return;
        end
        sz  = q.size();
        pop = (sz > 0) && out_rdy;
        if (pop) r = q.pop_front();
        fr = DEPTH - sz + (pop ? 1 : 0);
        wr = 0; nv = 0; dr = 0;
        for (int i = 0; i < NCH; i++) begin
            if (commit_val[i]) begin
                nv++;
                if (wr < fr) begin
                    r.ch = i; r.pc = pcv[i]; r.data = dv[i];
`ifdef CORE_COMMIT_TS_EN
                    r.ts = m_ts;
`else
                    r.ts = 0;
`endif
                    q.push_back(r);
                    wr++;
                end else dr++;
            end
        end
        m_cnt = m_cnt + 32'(nv);
        s = longint'(m_drop) + longint'(dr);
        m_drop = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
        if (dr > 0) m_ovf = 1;
        m_ts = m_ts + 1;
    endtask

    task automatic compare_model();
        chk("out_val", out_val, q.size() > 0);
        chk("level", level, q.size());
        chk("commit_cnt", commit_cnt, m_cnt);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("ovf", ovf, m_ovf);
        if (q.size() > 0) begin
            chk("out_ch", out_ch, q[0].ch);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_data", out_data, q[0].data);
            chk("out_ts", out_ts, q[0].ts);
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle(bit r, logic [NCH-1:0] v, bit rdy);
        drive(r, v, rdy);
        #4;
        compare_model();
        finish_cycle();
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [31:0] p0, p1, d0;
        bit          rdy;
        bit          e_val;
        logic [31:0] e_pc;
        int          e_ch, e_lvl, e_cnt;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] got_pc[$];
    logic [31:0] exp_pc;
    int          bias;

    initial begin
        for (int i = 0; i < NCH; i++) begin pcv[i] = 0; dv[i] = 0; end
        drive(1, '0, 0);
        repeat (2) @(posedge clk);
        model_update();
        #1;
        chk("rst out_val", out_val, 0);
        chk("rst level", level, 0);
        chk("rst commit_cnt", commit_cnt, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        chk("rst ovf", ovf, 0);
        chk("rst out_pc", out_pc, 0);
        chk("rst out_ch", out_ch, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_ts", out_ts, 0);

        // Single commit, then a two-channel commit drained in channel order.
        tbl[0] = '{2'b01, 32'h100, 32'h0,   32'h5,   1, 0, 32'h0,   0, 0, 0};
        tbl[1] = '{2'b00, 32'h0,   32'h0,   32'h0,   1, 1, 32'h100, 0, 1, 1};
        tbl[2] = '{2'b11, 32'h200, 32'h204, 32'h2a,  1, 0, 32'h0,   0, 0, 1};
        tbl[3] = '{2'b00, 32'h0,   32'h0,   32'h0,   1, 1, 32'h200, 0, 2, 3};
        tbl[4] = '{2'b00, 32'h0,   32'h0,   32'h0,   1, 1, 32'h204, 1, 1, 3};
        tbl[5] = '{2'b00, 32'h0,   32'h0,   32'h0,   0, 0, 32'h0,   0, 0, 3};
        for (int k = 0; k < 6; k++) begin
            pcv[0] = tbl[k].p0; pcv[1] = tbl[k].p1;
            dv[0]  = tbl[k].d0; dv[1]  = tbl[k].p1 ^ 32'h1;
            drive(0, tbl[k].v, tbl[k].rdy);
            #4;
            chk($sformatf("tbl%0d out_val", k), out_val, tbl[k].e_val);
            chk($sformatf("tbl%0d level", k), level, tbl[k].e_lvl);
            chk($sformatf("tbl%0d commit_cnt", k), commit_cnt, tbl[k].e_cnt);
            if (tbl[k].e_val) begin
                chk($sformatf("tbl%0d out_pc", k), out_pc, tbl[k].e_pc);
                chk($sformatf("tbl%0d out_ch", k), out_ch, tbl[k].e_ch);
            end
            compare_model();
            finish_cycle();
        end

        // Overflow: nine commits into an 8-deep FIFO with the consumer stalled.
        cycle(1, '0, 0);
        for (int i = 0; i < 9; i++) begin
            pcv[0] = 32'h300 + 32'(i * 4); dv[0] = 32'(i);
            cycle(0, 2'b01, 0);
        end
        pcv[0] = 32'h400; pcv[1] = 32'h404; dv[0] = 32'h40; dv[1] = 32'h41;
        drive(0, 2'b11, 1);
        #4;
        chk("full level", level, 8);
        chk("full drop_cnt", drop_cnt, 1);
        chk("full ovf", ovf, 1);
        chk("full head pc", out_pc, 32'h300);
        compare_model();
        finish_cycle();
        drive(0, '0, 0);
        #4;
        chk("pop+write level", level, 8);
        chk("pop+write drop_cnt", drop_cnt, 2);
        compare_model();
        finish_cycle();
        for (int k = 0; k < 8; k++) begin
            drive(0, '0, 1);
            #4;
            exp_pc = (k < 7) ? 32'h304 + 32'(k * 4) : 32'h400;
            chk($sformatf("drain%0d out_pc", k), out_pc, exp_pc);
            compare_model();
            finish_cycle();
        end
        drive(0, '0, 1);
        #4;
        chk("drained level", level, 0);
        compare_model();
        finish_cycle();

        // Streaming 20 commits across pointer wrap.
        got_pc.delete();
        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < NCH; c++) begin
                pcv[c] = 32'h1000 + 32'(i * 4); dv[c] = 32'(i);
            end
            drive(0, (i < 20) ? 2'(1 << (i % 2)) : 2'b00, 1);
            #4;
            if (out_val) got_pc.push_back(out_pc);
            compare_model();
            finish_cycle();
        end
        chk("stream count", got_pc.size(), 20);
        for (int i = 0; i < 20 && i < got_pc.size(); i++)
            chk($sformatf("stream%0d pc", i), got_pc[i], 32'h1000 + 32'(i * 4));

        // Timestamp of a commit five cycles after reset, then mid-stream reset.
        cycle(1, '0, 0);
        for (int i = 0; i < 5; i++) cycle(0, '0, 0);
        pcv[0] = 32'h500; dv[0] = 32'h55;
        cycle(0, 2'b01, 0);
        drive(0, '0, 0);
        #4;
        chk("ts pc", out_pc, 32'h500);
`ifdef CORE_COMMIT_TS_EN
        chk("ts value", out_ts, 5);
`else
        chk("ts value", out_ts, 0);
`endif
        compare_model();
        finish_cycle();
        for (int i = 0; i < 5; i++) cycle(0, 2'b11, 0);
        cycle(1, 2'b11, 0);
        drive(0, '0, 1);
        #4;
        chk("midrst level", level, 0);
        chk("midrst ovf", ovf, 0);
        chk("midrst out_val", out_val, 0);
        chk("midrst drop_cnt", drop_cnt, 0);
        compare_model();
        finish_cycle();

        // Randomized traffic with phases of varying consumer readiness.
        bias = 2;
        for (int n = 0; n < 2000; n++) begin
            if (n % 100 == 0) bias = $urandom_range(0, 4);
            for (int c = 0; c < NCH; c++) begin pcv[c] = $urandom; dv[c] = $urandom; end
            cycle(($urandom_range(0, 249) == 0), NCH'($urandom), ($urandom_range(0, 3) < bias));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_commit_tracer.md
CORE_COMMIT_TRACER -- requirements
Module: core_commit_tracer

Interface
REQ-001 SHALL have parameter NCH, default 2, number of commit channels (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of 2, >= 4).
REQ-003 SHALL have parameter XLEN, default 32, width of pc and data fields.
REQ-004 SHALL have parameter CNT_W, default 32, width of commit_cnt and drop_cnt.
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port commit_val  input  NCH  per-channel commit valid.
REQ-008 SHALL have port commit_pc  input  NCH*XLEN  per-channel pc; channel i at bits [i*XLEN +: XLEN].
REQ-009 SHALL have port commit_data  input  NCH*XLEN  per-channel writeback data, same packing as commit_pc.
REQ-010 SHALL have port out_val  output  1  head record valid.
REQ-011 SHALL have port out_rdy  input  1  consumer accepts head record.
REQ-012 SHALL have port out_ch  output  $clog2(NCH) (min 1)  channel index of head record.
REQ-013 SHALL have port out_pc  output  XLEN  pc of head record.
REQ-014 SHALL have port out_data  output  XLEN  data of head record.
REQ-015 SHALL have port out_ts  output  32  timestamp of head record.
REQ-016 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 SHALL have port commit_cnt  output  CNT_W  total commits seen, accepted or dropped; wraps.
REQ-018 SHALL have port drop_cnt  output  CNT_W  commits dropped for lack of space; saturates at all-ones.
REQ-019 SHALL have port ovf  output  1  sticky flag, set on the first drop.

Function
REQ-020 SHALL treat a pop as occurring in a cycle when out_val && out_rdy.
REQ-021 SHALL compute free = DEPTH - level + pop each cycle; a slot freed by a pop is reusable in the same cycle.
REQ-022 SHALL write valid channels in ascending index order into consecutive FIFO slots, up to free.
REQ-023 SHALL drop valid channels beyond free, add their count to drop_cnt, and set ovf in the same cycle.
REQ-024 SHALL update level to level + written - pop at the next posedge.
REQ-025 SHALL drive out_val from registered state only; a commit into an empty FIFO appears on out_val one cycle later.
REQ-026 SHALL hold out_ch, out_pc, out_data and out_ts stable while out_val && !out_rdy.
REQ-027 SHALL wrap read and write pointers modulo DEPTH, with no bubble at wrap.
REQ-028 SHALL increment commit_cnt by popcount(commit_val) every cycle.
REQ-029 SHALL ignore out_rdy when out_val is 0, with no state change.

Reset
REQ-030 SHALL, while rst=1 at posedge, set level=0, out_val=0, out_ch=0, out_pc=0, out_data=0, out_ts=0, commit_cnt=0, drop_cnt=0, ovf=0, pointers=0, and the timestamp counter to 0.
REQ-031 SHALL discard all buffered records and any same-cycle commits when reset asserts mid-operation.
REQ-032 SHALL accept commits in the first cycle with rst=0.

Configuration
REQ-033 SHALL, with CORE_COMMIT_TS_EN defined, run a 32-bit cycle counter (0 after reset, +1 every cycle, wraps) and store its value with each record in the commit cycle.
REQ-034 SHALL, without CORE_COMMIT_TS_EN, omit the counter and timestamp storage and tie out_ts to 0; all other behaviour is identical.

Verification
REQ-035 SHALL cover: single commit, ch0 pc=0x100 data=0x5, FIFO empty, out_rdy=1 -> out_val=1 the next cycle with pc=0x100, ch=0, then level=0.
REQ-036 SHALL cover: both channels valid in one cycle, pc 0x200 (ch0) and 0x204 (ch1) -> two records popped in order ch0 then ch1; commit_cnt=2.
REQ-037 SHALL cover: out_rdy=0, 9 single commits with DEPTH=8 -> level=8, drop_cnt=1, ovf=1; the 9th pc is never output.
REQ-038 SHALL cover: FIFO full, pop plus two valid channels in the same cycle -> ch0 written, ch1 dropped, level stays 8, drop_cnt +1.
REQ-039 SHALL cover: 20 commits streamed with out_rdy=1 -> pointer wrap is lossless and the output order matches input.
REQ-040 SHALL cover: with CORE_COMMIT_TS_EN, a commit at cycle 5 after reset -> out_ts=5; without the macro -> out_ts=0; rst mid-stream -> level=0, ovf=0.
